dds_word_serializer: RTL and testbench
======================================

DDS_WORD_SERIALIZER -- requirements
Module: dds_word_serializer

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 11, giving the instruction word width in bits.
REQ-002 The block SHALL have parameter CLK_DIV, default 2, giving clk cycles per sclk half-period (legal 1..255).
REQ-003 The block SHALL have parameter UPDATE_CYCLES, default 2, giving the io_update pulse length in clk cycles (legal 1..255).
REQ-004 The block SHALL have port clk, input, 1 bit: single clock for all logic.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port din, input, DATA_WIDTH bits: instruction word from block-memory playback.
REQ-007 The block SHALL have port din_valid, input, 1 bit: one-cycle strobe marking din as a new word.
REQ-008 The block SHALL have port sclk, output, 1 bit: DDS serial clock.
REQ-009 The block SHALL have port sdio, output, 1 bit: DDS serial data, MSB first.
REQ-010 The block SHALL have port csb, output, 1 bit: DDS chip select, active-low.
REQ-011 The block SHALL have port io_update, output, 1 bit: DDS register-transfer pulse.
REQ-012 The block SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.
REQ-013 The block SHALL have port overrun, output, 1 bit: sticky flag that a word was dropped.

Function
REQ-014 The FSM SHALL have states IDLE, SHIFT and UPDATE; all outputs are registered.
REQ-015 IDLE with din_valid=1 at cycle T -> at T+1: state SHIFT, csb=0, sclk=0, sdio=din[DATA_WIDTH-1], bit counter=DATA_WIDTH-1.
REQ-016 Each bit SHALL occupy 2*CLK_DIV cycles: sclk low for CLK_DIV cycles, then high for CLK_DIV cycles; sdio changes only with sclk falling or at frame start.
REQ-017 After the high phase of bit 0 -> state UPDATE, csb=1, sclk=0, sdio=0, io_update=1 for exactly UPDATE_CYCLES cycles.
REQ-018 The frame length from the first csb=0 cycle to the first io_update=0 cycle SHALL be 2*CLK_DIV*DATA_WIDTH+UPDATE_CYCLES cycles (46 with defaults).
REQ-019 A one-entry holding buffer SHALL capture din when din_valid=1 and busy=1.
REQ-020 din_valid while busy with the buffer full -> new word dropped, buffer unchanged, overrun=1 from the next cycle until reset.
REQ-021 On the last UPDATE cycle with the buffer full -> next cycle starts a frame from the buffer (REQ-015 timing) and the buffer empties; no IDLE cycle.
REQ-022 din_valid on the last UPDATE cycle with the buffer empty -> word is buffered and starts next cycle as in REQ-021.
REQ-023 din_valid while csb=1 in IDLE SHALL never be dropped.
REQ-024 Bit counter and divider widths SHALL be derived from DATA_WIDTH and CLK_DIV without overflow.

Reset
REQ-025 reset=1 at a clk edge -> next cycle: state IDLE, sclk=0, sdio=0, csb=1, io_update=0, busy=0, overrun=0, buffer empty.
REQ-026 Reset mid-frame SHALL abort the frame with no io_update pulse; din_valid during reset is ignored.

Configuration
REQ-027 With macro DDS_SER_OVERRUN_CNT_EN defined: extra output overrun_count, 8 bits, increments on each dropped word, saturates at 255, clears on reset.
REQ-028 Without DDS_SER_OVERRUN_CNT_EN: no overrun_count port or logic; all other behaviour is identical.

Verification
REQ-029 Defaults, reset, then din=11'h5A3 strobed once -> sdio bits 1,0,1,1,0,1,0,0,0,1,1 sampled on 11 sclk rises; csb low 44 cycles; io_update high 2 cycles; busy low at frame start+46.
REQ-030 Three strobes at cycles 0, 10 and 20 (defaults) -> words 1 and 2 sent back-to-back with no IDLE cycle; word 3 dropped; overrun=1 from cycle 21; overrun_count=1 when enabled.
REQ-031 Strobe on the last UPDATE cycle -> next frame's csb falls on the immediately following cycle.
REQ-032 Reset asserted at frame cycle 20 -> csb=1, io_update=0, busy=0 the next cycle; no io_update seen until a new strobe.
REQ-033 CLK_DIV=1, UPDATE_CYCLES=1, DATA_WIDTH=8, din=8'h81 -> sclk period 2 cycles; frame 17 cycles; sdio pattern 1,0,0,0,0,0,0,1.
REQ-034 With macro enabled, 300 drops -> overrun_count holds at 255.

Source files
------------

// File: rtl/dds_word_serializer.sv
// Serializes instruction words MSB-first onto a DDS serial port (sclk/sdio/csb), then pulses io_update.
// Define DDS_SER_OVERRUN_CNT_EN to add an 8-bit saturating overrun_count output.
`timescale 1ns/1ps
module dds_word_serializer #(
  parameter int DATA_WIDTH    = 11,
  parameter int CLK_DIV       = 2,
  parameter int UPDATE_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  din_valid,
  output logic                  sclk,
  output logic                  sdio,
  output logic                  csb,
  output logic                  io_update,
  output logic                  busy,
`ifdef DDS_SER_OVERRUN_CNT_EN
  output logic [7:0]            overrun_count,
`endif
  output logic                  overrun
);

  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int UPD_W = (UPDATE_CYCLES > 1) ? $clog2(UPDATE_CYCLES) : 1;

  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [UPD_W-1:0] UPD_LAST = UPD_W'(UPDATE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    UPDATE
  } state_t;

  state_t                state_q, state_d;
  logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
  logic [UPD_W-1:0]      upd_cnt_q, upd_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] buf_q, buf_d;
  logic                  buf_full_q, buf_full_d;
  logic                  sclk_q, sclk_d;
  logic                  sdio_q, sdio_d;
  logic                  csb_q, csb_d;
  logic                  io_update_q, io_update_d;
  logic                  busy_q, busy_d;
  logic                  overrun_q, overrun_d;

  logic                  start_frame;
  logic [DATA_WIDTH-1:0] start_word;
  logic                  drop;
  logic                  last_upd;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      div_cnt_q   <= '0;
      upd_cnt_q   <= '0;
      shift_q     <= '0;
      buf_q       <= '0;
      buf_full_q  <= 1'b0;
      sclk_q      <= 1'b0;
      sdio_q      <= 1'b0;
      csb_q       <= 1'b1;
      io_update_q <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      div_cnt_q   <= div_cnt_d;
      upd_cnt_q   <= upd_cnt_d;
      shift_q     <= shift_d;
      buf_q       <= buf_d;
      buf_full_q  <= buf_full_d;
      sclk_q      <= sclk_d;
      sdio_q      <= sdio_d;
      csb_q       <= csb_d;
      io_update_q <= io_update_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    div_cnt_d   = div_cnt_q;
    upd_cnt_d   = upd_cnt_q;
    shift_d     = shift_q;
    buf_d       = buf_q;
    buf_full_d  = buf_full_q;
    sclk_d      = sclk_q;
    sdio_d      = sdio_q;
    csb_d       = csb_q;
    io_update_d = io_update_q;
    busy_d      = busy_q;
    start_frame = 1'b0;
    start_word  = din;
    drop        = 1'b0;
    last_upd    = (state_q == UPDATE) && (upd_cnt_q == UPD_LAST);

    // On the last UPDATE cycle an empty buffer lets din start the next frame directly.
    if (din_valid && busy_q) begin
      if (buf_full_q) begin
        drop = 1'b1;
      end else if (!last_upd) begin
        buf_d      = din;
        buf_full_d = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (din_valid) start_frame = 1'b1;
      end
      SHIFT: begin
        if (div_cnt_q == DIV_LAST) begin
          div_cnt_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else if (bit_cnt_q == '0) begin
            state_d     = UPDATE;
            csb_d       = 1'b1;
            sclk_d      = 1'b0;
            sdio_d      = 1'b0;
            io_update_d = 1'b1;
            upd_cnt_d   = '0;
          end else begin
            sclk_d    = 1'b0;
            bit_cnt_d = bit_cnt_q - BIT_W'(1);
            sdio_d    = shift_q[bit_cnt_q - BIT_W'(1)];
          end
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end
      UPDATE: begin
        if (last_upd) begin
          if (buf_full_q) begin
            start_frame = 1'b1;
            start_word  = buf_q;
            buf_full_d  = 1'b0;
          end else if (din_valid) begin
            start_frame = 1'b1;
          end else begin
            state_d     = IDLE;
            io_update_d = 1'b0;
            busy_d      = 1'b0;
          end
        end else begin
          upd_cnt_d = upd_cnt_q + UPD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (start_frame) begin
      state_d     = SHIFT;
      csb_d       = 1'b0;
      sclk_d      = 1'b0;
      sdio_d      = start_word[DATA_WIDTH-1];
      shift_d     = start_word;
      bit_cnt_d   = BIT_LAST;
      div_cnt_d   = '0;
      io_update_d = 1'b0;
      busy_d      = 1'b1;
    end

    overrun_d = overrun_q | drop;
  end

`ifdef DDS_SER_OVERRUN_CNT_EN
  logic [7:0] ovr_cnt_q;

  // Saturates so a long burst of drops never wraps back to a small count.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovr_cnt_q <= '0;
    end else if (drop && (ovr_cnt_q != 8'hFF)) begin
      ovr_cnt_q <= ovr_cnt_q + 8'd1;
    end
  end

  assign overrun_count = ovr_cnt_q;
`endif

  assign sclk      = sclk_q;
  assign sdio      = sdio_q;
  assign csb       = csb_q;
  assign io_update = io_update_q;
  assign busy      = busy_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_dds_word_serializer.sv
// Bench for dds_word_serializer: frame-timeline reference model checked every cycle, plus literal directed checks.
`timescale 1ns/1ps
module tb_dds_word_serializer;

  localparam int CD        = 2;
  localparam int DW        = 11;
  localparam int UC        = 2;
  localparam int SHIFT_LEN = 2 * CD * DW;
  localparam int FRAME_LEN = SHIFT_LEN + UC;

  logic          clk       = 1'b0;
  logic          reset     = 1'b1;
  logic [DW-1:0] din       = '0;
  logic          din_valid = 1'b0;
  logic          sclk, sdio, csb, io_update, busy, overrun;

  logic          b_reset = 1'b1;
  logic          b_dv    = 1'b0;
  logic [7:0]    b_din   = '0;
  logic          b_sclk, b_sdio, b_csb, b_io, b_busy, b_overrun;

`ifdef DDS_SER_OVERRUN_CNT_EN
  logic [7:0]    overrun_count, b_overrun_count;
  logic [7:0]    c_cnt;
`endif

  int  n_cmp  = 0;
  int  n_fail = 0;
  bit  chk_en = 1'b0;

  logic c_sclk, c_sdio, c_csb, c_io, c_busy, c_overrun;
  logic cb_sclk, cb_sdio, cb_csb, cb_io, cb_busy, cb_overrun;

  always #5 clk = ~clk;

  dds_word_serializer #(.DATA_WIDTH(DW), .CLK_DIV(CD), .UPDATE_CYCLES(UC)) dut (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
    .sclk(sclk), .sdio(sdio), .csb(csb), .io_update(io_update), .busy(busy),
`ifdef DDS_SER_OVERRUN_CNT_EN
    .overrun_count(overrun_count),
`endif
    .overrun(overrun)
  );

  dds_word_serializer #(.DATA_WIDTH(8), .CLK_DIV(1), .UPDATE_CYCLES(1)) dut_b (
    .clk(clk), .reset(b_reset), .din(b_din), .din_valid(b_dv),
    .sclk(b_sclk), .sdio(b_sdio), .csb(b_csb), .io_update(b_io), .busy(b_busy),
`ifdef DDS_SER_OVERRUN_CNT_EN
    .overrun_count(b_overrun_count),
`endif
    .overrun(b_overrun)
  );

  // Reference model: a frame is a word plus its start cycle; outputs follow from the offset.
  int            m_cyc      = 0;
  int            m_start    = 0;
  bit            m_active   = 1'b0;
  logic [DW-1:0] m_word     = '0;
  logic [DW-1:0] m_buf      = '0;
  bit            m_buf_full = 1'b0;
  bit            m_overrun  = 1'b0;
  int            m_cnt      = 0;

  always @(posedge clk) begin
    automatic bit            act     = m_active;
    automatic int            st      = m_start;
    automatic logic [DW-1:0] w       = m_word;
    automatic logic [DW-1:0] bf      = m_buf;
    automatic bit            full    = m_buf_full;
    automatic bit            ovr     = m_overrun;
    automatic int            cnt     = m_cnt;
    automatic bit            drop    = 1'b0;
    automatic bit            is_last = m_active && ((m_cyc - m_start) == FRAME_LEN - 1);
    if (reset) begin
      act  = 1'b0;
      full = 1'b0;
      ovr  = 1'b0;
      cnt  = 0;
    end else if (!act) begin
      if (din_valid) begin
        act = 1'b1;
        st  = m_cyc + 1;
        w   = din;
      end
    end else if (is_last) begin
      if (full) begin
        st   = m_cyc + 1;
        w    = bf;
        full = 1'b0;
        drop = din_valid;
      end else if (din_valid) begin
        st = m_cyc + 1;
        w  = din;
      end else begin
        act = 1'b0;
      end
    end else if (din_valid) begin
      if (full) begin
        drop = 1'b1;
      end else begin
        bf   = din;
        full = 1'b1;
      end
    end
    if (drop) begin
      ovr = 1'b1;
      if (cnt < 255) cnt = cnt + 1;
    end
    m_active   <= act;
    m_start    <= st;
    m_word     <= w;
    m_buf      <= bf;
    m_buf_full <= full;
    m_overrun  <= ovr;
    m_cnt      <= cnt;
    m_cyc      <= m_cyc + 1;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_cmp++;
    if (actual != expected) begin
      n_fail++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      automatic int   off    = m_cyc - m_start;
      automatic logic e_sclk = 1'b0;
      automatic logic e_sdio = 1'b0;
      automatic logic e_csb  = 1'b1;
      automatic logic e_io   = 1'b0;
      automatic logic e_busy = 1'b0;
      if (m_active) begin
        e_busy = 1'b1;
        if (off < SHIFT_LEN) begin
          e_csb  = 1'b0;
          e_sclk = ((off % (2 * CD)) >= CD);
          e_sdio = m_word[DW - 1 - off / (2 * CD)];
        end else begin
          e_io = 1'b1;
        end
      end
      checkOutput("model_sclk", sclk, e_sclk);
      checkOutput("model_sdio", sdio, e_sdio);
      checkOutput("model_csb", csb, e_csb);
      checkOutput("model_io_update", io_update, e_io);
      checkOutput("model_busy", busy, e_busy);
      checkOutput("model_overrun", overrun, m_overrun);
`ifdef DDS_SER_OVERRUN_CNT_EN
      checkOutput("model_overrun_count", overrun_count, m_cnt);
`endif
    end
  end

  // Captures the outputs of the current cycle, then drives the inputs for it.
  task automatic applyStimulus(input logic dv, input logic [DW-1:0] d, input logic rst);
    @(negedge clk);
    c_sclk     = sclk;     c_sdio  = sdio;   c_csb  = csb;
    c_io       = io_update; c_busy = busy;   c_overrun = overrun;
    cb_sclk    = b_sclk;   cb_sdio = b_sdio; cb_csb = b_csb;
    cb_io      = b_io;     cb_busy = b_busy; cb_overrun = b_overrun;
`ifdef DDS_SER_OVERRUN_CNT_EN
    c_cnt      = overrun_count;
`endif
    din_valid  = dv;
    din        = d;
    reset      = rst;
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [DW-1:0] bits;
    logic [7:0]    bbits;
    int            nb, lowc, ioc, fcsb, fio, idle_c, r1, r2;
    bit            prev, seen_io;

    applyStimulus(1'b1, 11'h7FF, 1'b1);
    applyStimulus(1'b0, '0, 1'b1);
    applyStimulus(1'b0, '0, 1'b0);
    b_reset = 1'b0;
    chk_en  = 1'b1;
    checkOutput("reset_csb", c_csb, 1);
    checkOutput("reset_busy", c_busy, 0);
    checkOutput("reset_io_update", c_io, 0);
    checkOutput("reset_overrun", c_overrun, 0);
    checkOutput("reset_b_csb", cb_csb, 1);

    // Single word 11'h5A3 with default timing.
    applyStimulus(1'b1, 11'h5A3, 1'b0);
    bits = '0; nb = 0; lowc = 0; ioc = 0; prev = 1'b0; fcsb = -1; fio = -1; seen_io = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      applyStimulus(1'b0, '0, 1'b0);
      if (c_sclk && !prev && nb < DW) begin
        bits = {bits[DW-2:0], c_sdio};
        nb++;
      end
      prev = c_sclk;
      if (!c_csb) lowc++;
      if (!c_csb && fcsb < 0) fcsb = i;
      if (c_io) begin
        ioc++;
        seen_io = 1'b1;
      end else if (seen_io && fio < 0) begin
        fio = i;
      end
      if (i == 1)  checkOutput("start_sdio_msb", c_sdio, 1);
      if (i == 46) checkOutput("busy_frame_plus_45", c_busy, 1);
      if (i == 47) checkOutput("busy_frame_plus_46", c_busy, 0);
    end
    checkOutput("word_5a3_bits", bits, 11'h5A3);
    checkOutput("word_5a3_bitcount", nb, 11);
    checkOutput("csb_low_cycles", lowc, 44);
    checkOutput("io_update_cycles", ioc, 2);
    checkOutput("frame_length", fio - fcsb, 46);

    // Strobes at cycles 0, 10, 20: two frames back-to-back, third word dropped.
    idle_c = 0;
    for (int i = 0; i <= 100; i++) begin
      applyStimulus((i == 0) || (i == 10) || (i == 20),
                    (i == 0) ? 11'h123 : (i == 10) ? 11'h456 : 11'h789, 1'b0);
      if (i >= 1 && i <= 92 && !c_busy) idle_c++;
      if (i == 20) checkOutput("overrun_before_drop", c_overrun, 0);
      if (i == 21) checkOutput("overrun_after_drop", c_overrun, 1);
`ifdef DDS_SER_OVERRUN_CNT_EN
      if (i == 21) checkOutput("overrun_count_one", c_cnt, 1);
`endif
      if (i == 46) checkOutput("b2b_last_update_io", c_io, 1);
      if (i == 47) checkOutput("b2b_second_csb_fall", c_csb, 0);
    end
    checkOutput("b2b_idle_cycles", idle_c, 0);

    // Strobe on the last UPDATE cycle with an empty buffer.
    applyStimulus(1'b0, '0, 1'b1);
    for (int i = 0; i <= 100; i++) begin
      applyStimulus((i == 0) || (i == 46), (i == 0) ? 11'h2AA : 11'h155, 1'b0);
      if (i == 46) checkOutput("late_strobe_csb_high", c_csb, 1);
      if (i == 47) checkOutput("late_strobe_csb_fall", c_csb, 0);
      if (i == 47) checkOutput("late_strobe_sdio", c_sdio, 0);
      if (i == 100) checkOutput("late_strobe_no_overrun", c_overrun, 0);
    end

    // Reset at frame cycle 20 aborts the frame.
    applyStimulus(1'b0, '0, 1'b1);
    ioc = 0;
    for (int i = 0; i <= 80; i++) begin
      applyStimulus(i == 0, 11'h3C5, i == 21);
      if (i == 21) checkOutput("abort_csb_before", c_csb, 0);
      if (i == 22) begin
        checkOutput("abort_csb", c_csb, 1);
        checkOutput("abort_io_update", c_io, 0);
        checkOutput("abort_busy", c_busy, 0);
      end
      if (i >= 22 && c_io) ioc++;
    end
    checkOutput("abort_no_io_update", ioc, 0);

    // Continuous strobes: many drops, counter saturates.
    applyStimulus(1'b0, '0, 1'b1);
    for (int i = 0; i < 400; i++) applyStimulus(1'b1, DW'($urandom), 1'b0);
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("saturate_overrun", c_overrun, 1);
`ifdef DDS_SER_OVERRUN_CNT_EN
    checkOutput("saturate_count", c_cnt, 255);
`endif

    // Randomized traffic with occasional resets.
    applyStimulus(1'b0, '0, 1'b1);
    for (int i = 0; i < 4000; i++) begin
      applyStimulus($urandom_range(0, 11) == 0, DW'($urandom), $urandom_range(0, 699) == 0);
    end
    applyStimulus(1'b0, '0, 1'b0);

    // Narrow instance: DATA_WIDTH=8, CLK_DIV=1, UPDATE_CYCLES=1, word 8'h81.
    b_dv = 1'b1; b_din = 8'h81;
    bbits = '0; nb = 0; prev = 1'b0; fcsb = -1; fio = -1; seen_io = 1'b0; r1 = -1; r2 = -1;
    for (int i = 1; i <= 30; i++) begin
      applyStimulus(1'b0, '0, 1'b0);
      b_dv = 1'b0;
      if (cb_sclk && !prev) begin
        if (nb < 8) bbits = {bbits[6:0], cb_sdio};
        nb++;
        if (r1 < 0) r1 = i;
        else if (r2 < 0) r2 = i;
      end
      prev = cb_sclk;
      if (!cb_csb && fcsb < 0) fcsb = i;
      if (cb_io) seen_io = 1'b1;
      else if (seen_io && fio < 0) fio = i;
    end
    checkOutput("narrow_bits", bbits, 8'h81);
    checkOutput("narrow_sclk_period", r2 - r1, 2);
    checkOutput("narrow_frame_length", fio - fcsb, 17);
    checkOutput("narrow_busy_end", cb_busy, 0);
    checkOutput("narrow_overrun", cb_overrun, 0);
`ifdef DDS_SER_OVERRUN_CNT_EN
    checkOutput("narrow_overrun_count", b_overrun_count, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
